fetch_ctrl: RTL and testbench

Sequences the `pc` register of the single-cycle RV32UI core. It drives the register's `next_pc` input every cycle and runs the instruction-memory request/acknowledge handshake. It presents each fetched instruction to the core, applies stall, redirect and halt, and traps into a sticky fault on a fetch timeout or a misaligned redirect target. It sits between `pc`, instruction memory and the decode/execute datapath.

---
 rtl/fetch_ctrl_if.sv | 17 +
 rtl/fetch_ctrl.sv | 127 ++++++++++++
 tb/tb_fetch_ctrl.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if - instruction-memory request/acknowledge bus.
//   imem_req    fetcher -> memory  fetch request
//   imem_addr   fetcher -> memory  fetch address
//   imem_ack    memory -> fetcher  response valid
//   imem_rdata  memory -> fetcher  instruction word, valid with imem_ack
// master: the fetch controller. slave: the instruction memory.
interface fetch_ctrl_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (output imem_req, output imem_addr,
                    input  imem_ack, input  imem_rdata);
    modport slave  (input  imem_req, input  imem_addr,
                    output imem_ack, output imem_rdata);
endinterface

// File: rtl/fetch_ctrl.sv
// fetch_ctrl - PC sequencer and instruction-fetch FSM for the single-cycle
// RV32UI core. Drives the external pc register's next_pc, runs the imem
// handshake, presents the fetched word, and applies stall/halt/redirect.
// A fetch timeout or a misaligned redirect target traps into a sticky FAULT.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   pc / next_pc        current PC in, next PC out (combinational)
//   imem                instruction-memory bus (master side)
//   instr, instr_valid  registered instruction, valid while executing
//   stall, halt         core back-pressure and stop request
//   redirect_valid/pc   taken branch/jump and its target
//   halted, fault       terminal-state flags
//   fault_cause/pc      01 timeout, 10 misaligned redirect; offending address
//   instret             retired-instruction counter (wraps)
module fetch_ctrl #(
    parameter logic [31:0] BASE_PC        = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       pc,
    output logic [31:0]       next_pc,
    fetch_ctrl_if.master      imem,
    output logic [31:0]       instr,
    output logic              instr_valid,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    input  logic              halt,
    output logic              halted,
    output logic              fault,
    output logic [1:0]        fault_cause,
    output logic [31:0]       fault_pc,
    output logic [31:0]       instret
);

    localparam logic [2:0] S_START = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_EXEC  = 3'd2;
    localparam logic [2:0] S_HALT  = 3'd3;
    localparam logic [2:0] S_FAULT = 3'd4;

    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b01;
    localparam logic [1:0] CAUSE_MISALIGN = 2'b10;

    // Last un-acked FETCH cycle before the timeout trap fires.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [2:0] state;
    logic [7:0] wait_cnt;
    logic       redirect_misaligned;

    assign redirect_misaligned = redirect_pc[1:0] != 2'b00;

    assign imem.imem_req  = (state == S_FETCH);
    assign imem.imem_addr = pc;
    assign instr_valid    = (state == S_EXEC);
    assign halted         = (state == S_HALT);
    assign fault          = (state == S_FAULT);

    // The pc register only moves on a retire: EXEC with no stall, no halt,
    // and no misaligned redirect. Everything else holds.
    always_comb begin
        next_pc = pc;
        if (state == S_EXEC && !stall && !halt) begin
            if (!redirect_valid)
                next_pc = pc + 32'd4;
            else if (!redirect_misaligned)
                next_pc = redirect_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_START;
            wait_cnt    <= '0;
            instr       <= '0;
            fault_cause <= '0;
            fault_pc    <= '0;
            instret     <= '0;
        end else begin
            case (state)
                S_START: begin
                    state    <= S_FETCH;
                    wait_cnt <= '0;
                end
                S_FETCH: begin
                    // An ack on the last allowed cycle still wins over the trap.
                    if (imem.imem_ack) begin
                        instr <= imem.imem_rdata;
                        state <= S_EXEC;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state       <= S_FAULT;
                        fault_cause <= CAUSE_TIMEOUT;
                        fault_pc    <= pc;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_EXEC: begin
                    if (stall) begin
                        state <= S_EXEC;
                    end else if (halt) begin
                        state <= S_HALT;
                    end else if (redirect_valid && redirect_misaligned) begin
                        state       <= S_FAULT;
                        fault_cause <= CAUSE_MISALIGN;
                        fault_pc    <= redirect_pc;
                    end else begin
                        instret  <= instret + 32'd1;
                        state    <= S_FETCH;
                        wait_cnt <= '0;
                    end
                end
                default: begin
                    // HALT and FAULT are absorbing until reset.
                    state <= state;
                end
            endcase
        end
    end

    // START only follows reset, so the pc register must still hold its reset value.
    a_start_pc: assert property (@(posedge clk) disable iff (!rst_n)
                                 (state == S_START) |-> (pc == BASE_PC));

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int          TO   = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic [31:0] instr;
    logic        instr_valid;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        halt = 1'b0;
    logic        halted;
    logic        fault;
    logic [1:0]  fault_cause;
    logic [31:0] fault_pc;
    logic [31:0] instret;

    fetch_ctrl_if bus ();

    always #5 clk = ~clk;

    // The external pc register the controller steers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc <= BASE;
        else        pc <= next_pc;
    end

    fetch_ctrl #(.BASE_PC(BASE), .TIMEOUT_CYCLES(TO)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pc             (pc),
        .next_pc        (next_pc),
        .imem           (bus),
        .instr          (instr),
        .instr_valid    (instr_valid),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .halted         (halted),
        .fault          (fault),
        .fault_cause    (fault_cause),
        .fault_pc       (fault_pc),
        .instret        (instret)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: phases of the fetch/execute lifecycle.
    localparam int M_BOOT = 0, M_WAIT = 1, M_RUN = 2, M_STOP = 3, M_TRAP = 4;
    int          m_st;
    int          m_wait;      // un-acked fetch cycles seen so far
    logic [31:0] m_pc, m_instr, m_instret, m_fpc;
    logic [1:0]  m_fc;

    task automatic model_reset();
        m_st = M_BOOT; m_wait = 0; m_pc = BASE; m_instr = '0;
        m_instret = '0; m_fpc = '0; m_fc = '0;
    endtask

    task automatic check_all(input logic [31:0] exp_np);
        chk("pc",          pc,            m_pc);
        chk("imem_addr",   bus.imem_addr, m_pc);
        chk("imem_req",    bus.imem_req,  m_st == M_WAIT);
        chk("instr_valid", instr_valid,   m_st == M_RUN);
        chk("halted",      halted,        m_st == M_STOP);
        chk("fault",       fault,         m_st == M_TRAP);
        chk("fault_cause", fault_cause,   m_fc);
        chk("fault_pc",    fault_pc,      m_fpc);
        chk("instr",       instr,         m_instr);
        chk("instret",     instret,       m_instret);
        chk("next_pc",     next_pc,       exp_np);
    endtask

    // One clock: drive at the falling edge, check, advance the model, wait.
    task automatic step(input logic ack, input logic [31:0] rdata, input logic stl,
                        input logic rv, input logic [31:0] rpc, input logic hlt);
        logic [31:0] exp_np;
        logic        bad_target;
        bus.imem_ack = ack; bus.imem_rdata = rdata;
        stall = stl; redirect_valid = rv; redirect_pc = rpc; halt = hlt;
        #1;
        bad_target = rv && (rpc % 4 != 0);
        exp_np = m_pc;
        if (m_st == M_RUN && !stl && !hlt && !bad_target)
            exp_np = rv ? rpc : m_pc + 32'd4;
        check_all(exp_np);
        case (m_st)
            M_BOOT: begin m_st = M_WAIT; m_wait = 0; end
            M_WAIT: begin
                if (ack) begin
                    m_instr = rdata; m_st = M_RUN;
                end else begin
                    m_wait++;
                    if (m_wait == TO) begin m_st = M_TRAP; m_fc = 2'b01; m_fpc = m_pc; end
                end
            end
            M_RUN: begin
                if (!stl) begin
                    if (hlt) m_st = M_STOP;
                    else if (bad_target) begin m_st = M_TRAP; m_fc = 2'b10; m_fpc = rpc; end
                    else begin m_instret++; m_st = M_WAIT; m_wait = 0; end
                end
            end
            default: ;
        endcase
        m_pc = exp_np;
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic fetch(input logic [31:0] w);
        step(1'b1, w, 1'b0, 1'b0, '0, 1'b0);
    endtask

    // Called at a falling edge; returns at a falling edge with reset released.
    task automatic apply_reset();
        bus.imem_ack = 1'b0; bus.imem_rdata = '0;
        stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; halt = 1'b0;
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_all(m_pc);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] words [3];
        logic [31:0] r;
        logic        a, s, h, rv;
        int          starve;
        words[0] = 32'h0000_0013; words[1] = 32'h0010_0093; words[2] = 32'h0020_0113;
        bus.imem_ack = 1'b0; bus.imem_rdata = '0;
        model_reset();
        @(negedge clk);

        // Sequential fetch, with a stray ack during START that must be dropped.
        apply_reset();
        step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, '0, 1'b0);
        chk("start_ack_dropped", instr, 32'h0);
        for (int i = 0; i < 3; i++) begin
            chk("seq_addr", bus.imem_addr, 32'(4 * i));
            chk("seq_req", bus.imem_req, 1'b1);
            fetch(words[i]);
            chk("seq_instr", instr, words[i]);
            chk("seq_valid", instr_valid, 1'b1);
            idle();
            chk("seq_valid_low", instr_valid, 1'b0);
        end
        chk("seq_instret", instret, 32'd3);

        // Aligned redirect from pc 0x4.
        apply_reset();
        idle(); fetch(32'h1111_1111); idle(); fetch(32'h2222_2222);
        chk("redir_pc_before", pc, 32'h4);
        step(1'b0, '0, 1'b0, 1'b1, 32'h1000_0000, 1'b0);
        chk("redir_pc", pc, 32'h1000_0000);
        chk("redir_addr", bus.imem_addr, 32'h1000_0000);

        // Misaligned redirect traps and stays dead.
        fetch(32'h3333_3333);
        step(1'b0, '0, 1'b0, 1'b1, 32'h0000_000A, 1'b0);
        chk("misal_fault", fault, 1'b1);
        chk("misal_cause", fault_cause, 2'b10);
        chk("misal_fpc", fault_pc, 32'hA);
        for (int i = 0; i < 10; i++) begin
            step(1'($urandom % 2), $urandom, 1'b0, 1'b0, '0, 1'b0);
            chk("misal_req", bus.imem_req, 1'b0);
            chk("misal_pc_held", pc, 32'h1000_0000);
        end

        // Fetch timeout at pc 0x4.
        apply_reset();
        idle(); fetch(32'h4444_4444); idle();
        for (int i = 0; i < TO; i++) begin
            chk("to_no_fault_yet", fault, 1'b0);
            idle();
        end
        chk("to_fault", fault, 1'b1);
        chk("to_cause", fault_cause, 2'b01);
        chk("to_fpc", fault_pc, 32'h4);

        // Ack on the last allowed cycle is accepted.
        apply_reset();
        idle();
        for (int i = 0; i < TO - 1; i++) idle();
        fetch(32'h5555_5555);
        chk("to_late_valid", instr_valid, 1'b1);
        chk("to_late_fault", fault, 1'b0);
        chk("to_late_instr", instr, 32'h5555_5555);

        // Stall beats halt and redirect; retire once released.
        apply_reset();
        idle(); fetch(32'h6666_6666);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'h7777_7777, 1'b1, 1'b1, 32'h40, 1'b1);
            chk("stall_pc", pc, 32'h0);
            chk("stall_instr", instr, 32'h6666_6666);
            chk("stall_valid", instr_valid, 1'b1);
            chk("stall_instret", instret, 32'h0);
        end
        idle();
        chk("stall_release_instret", instret, 32'h1);
        chk("stall_release_pc", pc, 32'h4);

        // Halt, then an asynchronous reset pulse in the middle of a fetch.
        apply_reset();
        idle(); fetch(32'h8888_8888); idle(); fetch(32'h9999_9999);
        step(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
        chk("halt_halted", halted, 1'b1);
        chk("halt_pc", pc, 32'h4);
        chk("halt_req", bus.imem_req, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, $urandom, 1'b0, 1'b0, '0, 1'b0);
        chk("halt_sticky", halted, 1'b1);

        apply_reset();
        idle(); fetch(32'hABCD_0013); idle(); idle();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_pc", pc, BASE);
        chk("arst_instr", instr, 32'h0);
        chk("arst_instret", instret, 32'h0);
        chk("arst_req", bus.imem_req, 1'b0);
        chk("arst_valid", instr_valid, 1'b0);
        chk("arst_halted", halted, 1'b0);
        chk("arst_fault", fault, 1'b0);
        chk("arst_cause", fault_cause, 2'b00);
        chk("arst_fpc", fault_pc, 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 32'hBAD0_BAD0, 1'b0, 1'b0, '0, 1'b0);
        chk("arst_late_ack", instr, 32'h0);
        chk("arst_first_addr", bus.imem_addr, BASE);
        chk("arst_first_req", bus.imem_req, 1'b1);

        // Randomized run against the model.
        apply_reset();
        starve = 0;
        for (int n = 0; n < 4000; n++) begin
            if ((m_st == M_STOP || m_st == M_TRAP) && ($urandom % 6 == 0)) begin
                apply_reset();
            end else begin
                if (starve == 0 && $urandom % 50 == 0) starve = $urandom_range(10, 20);
                a = (starve == 0) && ($urandom % 10 < 6);
                if (starve > 0) starve--;
                s  = ($urandom % 5 == 0);
                h  = ($urandom % 60 == 0);
                rv = ($urandom % 4 == 0);
                r  = $urandom;
                if ($urandom % 8 != 0) r[1:0] = 2'b00;
                step(a, $urandom, s, rv, r, h);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
